// File: rtl/srlzr_pkg.sv
// Shared state encoding and sizing helpers for the PISO sequencer.
// Define SRLZR_PARITY_EN to append an even-parity bit to every frame.
package srlzr_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_e;

`ifdef SRLZR_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    function automatic int unsigned frame_w(input int unsigned data_width);
        return data_width + PARITY_BITS;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/srlzr_baud_cnt.sv
// Bit-period counter: advances only while running and enabled, wraps on terminal count.
module srlzr_baud_cnt
    import srlzr_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned BAUD_W = cnt_w(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [BAUD_W-1:0] r_cnt;
    logic              w_step;

    assign w_step = i_run && i_en;
    assign o_tc   = w_step && (r_cnt == BAUD_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tc) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/srlzr_ctrl.sv
// Serializer sequencer: accepts a word, strobes PISO load then shifts at the bit rate,
// then holds off for an inter-frame gap. Parity bit added when SRLZR_PARITY_EN is defined.
module srlzr_ctrl
    import srlzr_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = 8,
    parameter  int unsigned CLKS_PER_BIT = 4,
    parameter  int unsigned IDLE_GAP     = 2,
    localparam int unsigned FRAME_W      = frame_w(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_s_valid,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_s_ready,
    output logic                  o_piso_load,
    output logic                  o_piso_shift,
    output logic [FRAME_W-1:0]    o_piso_data,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int unsigned BIT_W = cnt_w(FRAME_W + 1);
    localparam int unsigned GAP_W = cnt_w(IDLE_GAP);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    state_e             r_state;
    state_e             w_state_d;
    logic               r_armed;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [BIT_W-1:0]   w_bit_cnt_d;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_cnt_d;
    logic [FRAME_W-1:0] r_data;
    logic [FRAME_W-1:0] w_frame;
    logic               w_accept;
    logic               w_tc;
    logic               w_last_bit;

`ifdef SRLZR_PARITY_EN
    assign w_frame = {^i_s_data, i_s_data};
`else
    assign w_frame = i_s_data;
`endif

    // r_armed keeps s_ready low until the first edge after reset release.
    assign o_s_ready   = (r_state == S_IDLE) && r_armed;
    assign w_accept    = o_s_ready && i_s_valid;
    assign o_busy      = (r_state != S_IDLE);
    assign o_piso_data = r_data;
    assign w_last_bit  = (r_bit_cnt == BIT_LAST);

    srlzr_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (r_state == S_LOAD),
        .i_run   (r_state == S_SHIFT),
        .i_en    (i_en),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_d    = r_state;
        w_bit_cnt_d  = r_bit_cnt;
        w_gap_cnt_d  = r_gap_cnt;
        o_piso_load  = 1'b0;
        o_piso_shift = 1'b0;
        o_frame_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                o_piso_load = 1'b1;
                w_bit_cnt_d = '0;
                w_state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_tc) begin
                    o_piso_shift = 1'b1;
                    w_bit_cnt_d  = r_bit_cnt + 1'b1;
                    if (w_last_bit) begin
                        o_frame_done = 1'b1;
                        w_gap_cnt_d  = '0;
                        w_state_d    = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_gap_cnt_d = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_armed   <= 1'b0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_armed   <= 1'b1;
            r_bit_cnt <= w_bit_cnt_d;
            r_gap_cnt <= w_gap_cnt_d;
            if (w_accept) begin
                r_data <= w_frame;
            end
        end
    end

endmodule

// File: tb/tb_srlzr_ctrl.sv
// Scoreboard bench for srlzr_ctrl: default instance (8/4/2) plus a CLKS_PER_BIT=1, IDLE_GAP=0 one.
module tb_srlzr_ctrl;

    localparam int unsigned DW  = 8;
    localparam int unsigned CPB = 4;
    localparam int unsigned GAP = 2;
`ifdef SRLZR_PARITY_EN
    localparam int unsigned FW = DW + 1;
`else
    localparam int unsigned FW = DW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b1;
    logic          s_valid = 1'b0;
    logic          v1 = 1'b0;
    logic [DW-1:0] s_data = '0;

    logic          s_ready, piso_load, piso_shift, busy, frame_done;
    logic [FW-1:0] piso_data;
    logic          o1_s_ready, o1_piso_load, o1_piso_shift, o1_busy, o1_frame_done;
    logic [FW-1:0] o1_piso_data;

    srlzr_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .IDLE_GAP(GAP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_s_valid(s_valid), .i_s_data(s_data),
        .o_s_ready(s_ready), .o_piso_load(piso_load), .o_piso_shift(piso_shift),
        .o_piso_data(piso_data), .o_busy(busy), .o_frame_done(frame_done)
    );

    srlzr_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1), .IDLE_GAP(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_s_valid(v1), .i_s_data(s_data),
        .o_s_ready(o1_s_ready), .o_piso_load(o1_piso_load), .o_piso_shift(o1_piso_shift),
        .o_piso_data(o1_piso_data), .o_busy(o1_busy), .o_frame_done(o1_frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_hs = 0;
    int last_t = 0;
    int n_shift_seen = 0;
    int pause_bit = 0;
    int pause_len = 0;
    logic prev_rdy = 1'b0;
    int q_load[$];
    int q_shift[$];
    int q_done[$];
    int q_rdy[$];
    logic [FW-1:0] q_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic [DW-1:0] d);
`ifdef SRLZR_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // Expected event labels: label L is the cycle ending at clock edge L.
    task automatic push_frame(input int t, input logic [DW-1:0] d);
        int s = 0;
        q_load.push_back(t + 1);
        q_data.push_back(mk_frame(d));
        for (int k = 1; k <= int'(FW); k++) begin
            s = t + 1 + k * int'(CPB) + ((pause_len > 0 && k >= pause_bit) ? pause_len : 0);
            q_shift.push_back(s);
        end
        q_done.push_back(s);
        q_rdy.push_back(s + int'(GAP) + 1);
        pause_len = 0;
        n_hs++;
        last_t = t;
    endtask

    task automatic flush();
        q_load.delete(); q_data.delete(); q_shift.delete(); q_done.delete(); q_rdy.delete();
    endtask

    task automatic monitor();
        int lbl = cyc + 1;
        int e;
        if (piso_load) begin
            e = (q_load.size() > 0) ? q_load.pop_front() : -1;
            chk("load_time", 32'(lbl), 32'(e));
            chk("load_data", 32'(piso_data), (q_data.size() > 0) ? 32'(q_data.pop_front()) : '1);
            chk("load_shift_excl", 32'(piso_shift), 32'd0);
        end
        if (piso_shift) begin
            n_shift_seen++;
            e = (q_shift.size() > 0) ? q_shift.pop_front() : -1;
            chk("shift_time", 32'(lbl), 32'(e));
        end
        if (frame_done) begin
            e = (q_done.size() > 0) ? q_done.pop_front() : -1;
            chk("done_time", 32'(lbl), 32'(e));
        end
        if (s_ready && !prev_rdy) begin
            e = (q_rdy.size() > 0) ? q_rdy.pop_front() : -1;
            chk("ready_time", 32'(lbl), 32'(e));
        end
        prev_rdy = s_ready;
    endtask

    task automatic tick();
        logic hs;
        hs = s_valid && s_ready;
        @(posedge clk);
        cyc++;
        if (hs) push_frame(cyc, s_data);
        #1;
        monitor();
    endtask

    task automatic wait_hs(input string tag, input int budget);
        int h = n_hs;
        int b = 0;
        while (n_hs == h && b < budget) begin
            tick();
            b++;
        end
        chk(tag, 32'(n_hs - h), 32'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int b = 0;
        while ((q_load.size() + q_shift.size() + q_done.size() + q_rdy.size()) > 0
               && b < budget) begin
            tick();
            b++;
        end
        chk(tag, 32'(q_load.size() + q_shift.size() + q_done.size() + q_rdy.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        flush();
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_load", 32'(piso_load), 32'd0);
        chk("rst_shift", 32'(piso_shift), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_data", 32'(piso_data), 32'd0);
        chk("rst1_busy", 32'(o1_busy), 32'd0);
        repeat (n) tick();
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", 32'(s_ready), 32'd0);
        q_rdy.push_back(cyc + 2);
        prev_rdy = 1'b0;
    endtask

    initial begin
        int t1;
        #1;
        // 1: reset held for 3 cycles, s_ready one edge after release
        do_reset(3);
        drain("rdy_after_reset", 4);

        // 2: single word
        s_data = 8'hA5; s_valid = 1'b1;
        wait_hs("hs_a5", 10);
        s_valid = 1'b0;
        drain("frame_a5", 60);

        // 3: back-to-back with s_valid held
        s_data = 8'h01; s_valid = 1'b1;
        wait_hs("hs_01", 10);
        t1 = last_t;
        s_data = 8'h02;
        wait_hs("hs_02", 60);
        chk("b2b_spacing", 32'(last_t - t1), 32'(2 + FW * CPB + GAP));
        s_valid = 1'b0;
        drain("frame_02", 60);

        // 4: en low for 7 cycles inside bit 3
        pause_bit = 3; pause_len = 7;
        s_data = 8'h3C; s_valid = 1'b1;
        wait_hs("hs_3c", 10);
        s_valid = 1'b0;
        t1 = last_t;
        while (cyc < t1 + 10) tick();
        en = 1'b0;
        repeat (7) tick();
        en = 1'b1;
        drain("frame_3c", 60);

        // 5: reset after the 4th shift abandons the frame
        s_data = 8'h5A; s_valid = 1'b1;
        wait_hs("hs_5a", 10);
        s_valid = 1'b0;
        n_shift_seen = 0;
        for (int b = 0; b < 40 && n_shift_seen < 4; b++) tick();
        chk("shifts_before_rst", 32'(n_shift_seen), 32'd4);
        do_reset(2);
        drain("rdy_after_rst2", 4);
        s_data = 8'h96; s_valid = 1'b1;
        wait_hs("hs_96", 10);
        s_valid = 1'b0;
        drain("frame_96", 60);

        // 6: CLKS_PER_BIT=1, IDLE_GAP=0 instance shifts on consecutive cycles
        s_data = 8'hC3; v1 = 1'b1;
        chk("d1_ready_idle", 32'(o1_s_ready), 32'd1);
        tick();
        v1 = 1'b0;
        for (int i = 1; i <= int'(FW) + 2; i++) begin
            chk("d1_load", 32'(o1_piso_load), 32'(i == 1));
            if (i == 1) chk("d1_data", 32'(o1_piso_data), 32'(mk_frame(8'hC3)));
            chk("d1_shift", 32'(o1_piso_shift), 32'(i >= 2 && i <= int'(FW) + 1));
            chk("d1_done", 32'(o1_frame_done), 32'(i == int'(FW) + 1));
            chk("d1_ready", 32'(o1_s_ready), 32'(i == int'(FW) + 2));
            tick();
        end

        chk("final_idle", 32'(busy), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
